lcd1602_host_driver: RTL
========================

Name: lcd1602_host_driver

Overview:
- Drives the host-side 16x2 character LCD (HD44780-compatible, 8-bit bus, write-only) from the two 128-bit row buffers produced by the host display stage (host_row1/host_row2).
- Runs the power-up/init command sequence once after reset.
- Then snapshots both rows and streams them to the panel, redrawing only when the row contents change.

Parameters:
- POWERUP_CYCLES, 150000, cycles idle after reset before the first command.
- EN_PULSE_CYCLES, 10, cycles lcd_en is held high per byte.
- CMD_WAIT_CYCLES, 500, cycles lcd_en is held low after each byte, for every byte except clear.
- CLEAR_WAIT_CYCLES, 20000, cycles lcd_en is held low after the clear command (0x01).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- row1  in  128  top row; bits [127:120] = column 0 ... bits [7:0] = column 15.
- row2  in  128  bottom row; same packing as row1.
- lcd_rs  out  1  0 = command, 1 = character data.
- lcd_rw  out  1  constant 0 (write only).
- lcd_en  out  1  panel enable strobe.
- lcd_data  out  8  panel data bus.
- busy  out  1  high except in S_IDLE.
- frame_done  out  1  one-cycle pulse at the end of each full redraw.

Behaviour:
- Reset (sync, rst=1 on a clk edge):
  - lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=0x00, busy=1, frame_done=0.
  - Shadow rows cleared to 0; state=S_PWR; all counters cleared.
  - Reset asserted mid-byte or mid-frame aborts immediately and restarts from S_PWR, including the full power-up wait.
- States:
  - S_PWR: count POWERUP_CYCLES cycles, then go to S_SETUP with init index 0.
  - S_SETUP: 1 cycle. Drive lcd_rs and lcd_data for the current byte; lcd_en=0.
  - S_PULSE: EN_PULSE_CYCLES cycles with lcd_en=1. rs/data held stable.
  - S_HOLD: lcd_en=0, rs/data held. Lasts CLEAR_WAIT_CYCLES if the byte was command 0x01, otherwise CMD_WAIT_CYCLES. Then advance the sequence index and return to S_SETUP, or go to S_IDLE after the last frame byte.
  - S_IDLE: busy=0, lcd_en=0.
- Byte timing: a normal byte takes exactly 1+EN_PULSE_CYCLES+CMD_WAIT_CYCLES cycles; back-to-back bytes have no gap cycles.
- Init sequence (rs=0): 0x38, 0x0C, 0x06, 0x01. It is followed immediately by the first frame.
- Frame sequence (34 bytes):
  - 0x80 (rs=0).
  - 16 row1 characters (rs=1), column 0 first.
  - 0xC0 (rs=0).
  - 16 row2 characters (rs=1).
- Snapshot: both rows are latched into shadow registers in the cycle the frame starts. The first frame after init always runs. Input changes during a frame never affect the bytes of that frame.
- Character mapping: shadow byte 0x00 is sent as 0x20 (space). All other values pass unchanged.
- frame_done: pulses for the single cycle in which the final S_HOLD of a frame ends; the state is S_IDLE on the next cycle.
- S_IDLE compare:
  - Each cycle, if {row1,row2} != shadow, latch new shadow and enter S_SETUP of a new frame the next cycle; busy goes high in that same next cycle.
  - If they are equal, remain in S_IDLE.
  - A change that arrived mid-frame is therefore redrawn starting one cycle after S_IDLE is entered.
- lcd_rw is 0 in every cycle.

Test Plan:
All tests use POWERUP_CYCLES=20, EN_PULSE_CYCLES=2, CMD_WAIT_CYCLES=4, CLEAR_WAIT_CYCLES=10.
1. Reset then release with rows constant -> first lcd_en rise 21 cycles after rst falls. Four init strobes with data 0x38, 0x0C, 0x06, 0x01 and rs=0. Each en-high lasts 2 cycles; the gap after 0x01 is 10 cycles. busy stays 1 throughout.
2. row1="HELLO" plus eleven 0x00 bytes, row2 all 0x41 -> frame bytes are 0x80, 48 45 4C 4C 4F, eleven 0x20, 0xC0, sixteen 0x41, with rs matching. frame_done pulses once, 238 cycles after the frame's first S_SETUP. busy=0 afterwards.
3. In idle, hold rows constant for 1000 cycles -> no lcd_en activity, busy=0, no frame_done.
4. In idle, change row2 column 15 to 0x5A -> busy=1 on the next cycle. The full 34-byte frame is resent and the last data byte is 0x5A.
5. Change row1 during byte 10 of a frame -> the current frame carries the old values. frame_done pulses; one cycle after S_IDLE is entered, a new frame starts with the new values.
6. Assert rst for 1 cycle mid-frame -> the next cycle has all outputs at reset values. A full 20-cycle power-up and init repeat before any frame byte.

Source files
------------

// File: rtl/lcd1602_host_driver.sv
// HD44780 16x2 LCD driver: one-time power-up/init sequence, then redraws both
// rows from a shadow snapshot whenever the host row buffers change.
module lcd1602_host_driver #(
    parameter int POWERUP_CYCLES    = 150000,
    parameter int EN_PULSE_CYCLES   = 10,
    parameter int CMD_WAIT_CYCLES   = 500,
    parameter int CLEAR_WAIT_CYCLES = 20000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] row1,
    input  logic [127:0] row2,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_en,
    output logic [7:0]   lcd_data,
    output logic         busy,
    output logic         frame_done
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_WAIT = max2(max2(POWERUP_CYCLES, EN_PULSE_CYCLES),
                                   max2(CMD_WAIT_CYCLES, CLEAR_WAIT_CYCLES));
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(EN_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYCLES - 1);

    // Sequence index: 0..3 init commands, 4..37 the 34 frame bytes.
    localparam logic [5:0] IDX_INIT_LAST   = 6'd3;
    localparam logic [5:0] IDX_FRAME_FIRST = 6'd4;
    localparam logic [5:0] IDX_ROW2_CMD    = 6'd21;
    localparam logic [5:0] IDX_LAST        = 6'd37;

    typedef enum logic [2:0] {
        S_PWR,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_IDLE
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [5:0]          idx, idx_nx;
    logic [31:0][7:0]    shadow;
    logic                snap;

    logic                cur_rs;
    logic [7:0]          cur_byte;
    logic [7:0]          raw_char;
    logic [4:0]          char_sel;
    logic [CNT_W-1:0]    hold_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_PWR;
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            if (snap) begin
                shadow <= {row1, row2};
            end
        end
    end

    // shadow[31] is row1 column 0, shadow[0] is row2 column 15.
    always_comb begin
        cur_rs   = 1'b0;
        cur_byte = 8'h00;
        char_sel = '0;
        raw_char = 8'h00;
        if (idx <= IDX_INIT_LAST) begin
            case (idx[1:0])
                2'd0:    cur_byte = 8'h38;
                2'd1:    cur_byte = 8'h0C;
                2'd2:    cur_byte = 8'h06;
                default: cur_byte = 8'h01;
            endcase
        end else if (idx == IDX_FRAME_FIRST) begin
            cur_byte = 8'h80;
        end else if (idx == IDX_ROW2_CMD) begin
            cur_byte = 8'hC0;
        end else begin
            cur_rs   = 1'b1;
            char_sel = (idx < IDX_ROW2_CMD) ? 5'(idx - 6'd5) : 5'(idx - 6'd6);
            raw_char = shadow[5'd31 - char_sel];
            cur_byte = (raw_char == 8'h00) ? 8'h20 : raw_char;
        end
    end

    // Only the clear command needs the long settle time; a data byte of 0x01 does not.
    assign hold_last = (!cur_rs && cur_byte == 8'h01) ? CLEAR_LAST : CMD_LAST;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 1'b1;
        idx_nx     = idx;
        snap       = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_PWR: begin
                if (cnt == PWR_LAST) begin
                    state_nx = S_SETUP;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            end
            S_SETUP: begin
                state_nx = S_PULSE;
                cnt_nx   = '0;
            end
            S_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_nx = S_HOLD;
                    cnt_nx   = '0;
                end
            end
            S_HOLD: begin
                if (cnt == hold_last) begin
                    cnt_nx = '0;
                    if (idx == IDX_LAST) begin
                        state_nx   = S_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        state_nx = S_SETUP;
                        idx_nx   = idx + 6'd1;
                        snap     = (idx == IDX_INIT_LAST);
                    end
                end
            end
            S_IDLE: begin
                cnt_nx = '0;
                if ({row1, row2} != shadow) begin
                    state_nx = S_SETUP;
                    idx_nx   = IDX_FRAME_FIRST;
                    snap     = 1'b1;
                end
            end
            default: begin
                state_nx = S_PWR;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        lcd_rs   = 1'b0;
        lcd_data = 8'h00;
        if (state == S_SETUP || state == S_PULSE || state == S_HOLD) begin
            lcd_rs   = cur_rs;
            lcd_data = cur_byte;
        end
    end

    assign lcd_rw = 1'b0;
    assign lcd_en = (state == S_PULSE);
    assign busy   = (state != S_IDLE);

endmodule
